// File: rtl/rom_select_arbiter.sv
// rom_select_arbiter: arbitrates NUM_CH read requesters onto one synchronous
// ROM port, registers the winning address and tags each in-flight read so the
// returned word is marked with its owner.
// Build option: define ROMSEL_FIXED_PRIO_EN for fixed lowest-index-wins
// priority; left undefined, arbitration is round-robin.
module rom_select_arbiter #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_CH-1:0]        Req,
  input  logic [NUM_CH*ADDR_W-1:0] Addr,
  output logic [NUM_CH-1:0]        Grant,
  output logic                     RomEn,
  output logic [ADDR_W-1:0]        RomAddr,
  input  logic [DATA_W-1:0]        RomData,
  output logic [DATA_W-1:0]        RdData,
  output logic [NUM_CH-1:0]        RdValid,
  output logic                     Busy
);

  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned STAGES = ROM_LAT + 1;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic [STAGES-1:0] tag_vld;
  logic [IDX_W-1:0]  tag_idx [STAGES];

  // Winner search: first requesting channel at or above ptr, wrapping round.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = {{(32-IDX_W){1'b0}}, ptr} + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!win_vld && Req[IDX_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
    // No grant may escape while the block is held in reset.
    if (!Reset_n) win_vld = 1'b0;
  end

  // One-hot grant decode of the winner.
  always_comb begin
    Grant = '0;
    if (win_vld) Grant[win_idx] = 1'b1;
  end

`ifdef ROMSEL_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at channel 0.
  always_comb begin
    ptr = '0;
  end
`else
  // Round-robin pointer moves just past the channel granted this edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (win_vld) begin
      ptr <= (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // ROM issue: strobe for one cycle per accepted request, address held otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RomEn   <= 1'b0;
      RomAddr <= '0;
    end else begin
      RomEn <= win_vld;
      if (win_vld) RomAddr <= Addr[win_idx*ADDR_W +: ADDR_W];
    end
  end

  // Tag pipeline: owner index travels alongside the read so it lines up with RomData.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag_vld <= '0;
      for (int unsigned s = 0; s < STAGES; s++) tag_idx[s] <= '0;
    end else begin
      tag_vld    <= {tag_vld[STAGES-2:0], win_vld};
      tag_idx[0] <= win_idx;
      for (int unsigned s = 1; s < STAGES; s++) tag_idx[s] <= tag_idx[s-1];
    end
  end

  // Return path: data passes straight through, owner decoded from the last stage.
  always_comb begin
    RdData  = RomData;
    RdValid = '0;
    if (tag_vld[STAGES-1]) RdValid[tag_idx[STAGES-1]] = 1'b1;
    Busy = |tag_vld;
  end

endmodule

// File: tb/tb_rom_select_arbiter.sv
// tb_rom_select_arbiter: directed checks of arbitration order, issue, tag
// alignment and reset behaviour, with a ROM_LAT=1 and a ROM_LAT=3 instance.
module tb_rom_select_arbiter;

  logic        clk;
  logic        reset_n;

  // ROM_LAT = 1 instance
  logic [3:0]  req;
  logic [39:0] addr;
  logic [3:0]  grant;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] rd_data;
  logic [3:0]  rd_valid;
  logic        busy;

  // ROM_LAT = 3 instance
  logic [3:0]  req3;
  logic [39:0] addr3;
  logic [3:0]  grant3;
  logic        rom_en3;
  logic [9:0]  rom_addr3;
  logic [31:0] rom_data3;
  logic [31:0] rd_data3;
  logic [3:0]  rd_valid3;
  logic        busy3;
  logic [31:0] rom_pipe3 [3];

  int checks = 0;
  int errors = 0;

  logic [9:0] a_val [4];

  rom_select_arbiter #(.NUM_CH(4), .ADDR_W(10), .DATA_W(32), .ROM_LAT(1)) u_dut (
    .Clk(clk), .Reset_n(reset_n), .Req(req), .Addr(addr), .Grant(grant),
    .RomEn(rom_en), .RomAddr(rom_addr), .RomData(rom_data), .RdData(rd_data),
    .RdValid(rd_valid), .Busy(busy)
  );

  rom_select_arbiter #(.NUM_CH(4), .ADDR_W(10), .DATA_W(32), .ROM_LAT(3)) u_dut3 (
    .Clk(clk), .Reset_n(reset_n), .Req(req3), .Addr(addr3), .Grant(grant3),
    .RomEn(rom_en3), .RomAddr(rom_addr3), .RomData(rom_data3), .RdData(rd_data3),
    .RdValid(rd_valid3), .Busy(busy3)
  );

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'h0, a};
  endfunction

  // Synchronous ROM models with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    rom_data     <= rom_en ? rom_word(rom_addr) : 32'hDEAD_BEEF;
    rom_pipe3[0] <= rom_en3 ? rom_word(rom_addr3) : 32'hDEAD_BEEF;
    rom_pipe3[1] <= rom_pipe3[0];
    rom_pipe3[2] <= rom_pipe3[1];
  end
  assign rom_data3 = rom_pipe3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_ch(input int k);
`ifdef ROMSEL_FIXED_PRIO_EN
    return 0;
`else
    return k % 4;
`endif
  endfunction

  initial begin
    reset_n = 1'b0;
    req     = 4'b1111;
    req3    = 4'b0000;
    addr3   = '0;
    for (int i = 0; i < 4; i++) begin
      a_val[i] = 10'h100 + 10'(i * 'h11);
      addr[i*10 +: 10] = a_val[i];
    end

    // Reset then idle; grant suppressed during reset even with requests.
    #1;
    check("grant_in_reset", 64'(grant), 64'h0);
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_rom_en", 64'(rom_en), 64'h0);
      check("rst_rom_addr", 64'(rom_addr), 64'h0);
      check("rst_rd_valid", 64'(rd_valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
    end
    reset_n = 1'b1;
    tick();
    check("idle_grant", 64'(grant), 64'h0);
    check("idle_rom_en", 64'(rom_en), 64'h0);
    check("idle_busy", 64'(busy), 64'h0);

    // Full contention for 8 cycles, then drain.
    for (int k = 0; k <= 10; k++) begin
      req = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) check("cont_grant", 64'(grant), 64'(4'b0001 << exp_ch(k)));
      else       check("cont_grant_idle", 64'(grant), 64'h0);
      if (k >= 1 && k <= 8) begin
        check("cont_rom_en", 64'(rom_en), 64'h1);
        check("cont_rom_addr", 64'(rom_addr), 64'(a_val[exp_ch(k-1)]));
      end else begin
        check("cont_rom_en_off", 64'(rom_en), 64'h0);
      end
      if (k >= 2 && k <= 9) begin
        check("cont_rd_valid", 64'(rd_valid), 64'(4'b0001 << exp_ch(k-2)));
        check("cont_rd_data", 64'(rd_data), 64'(rom_word(a_val[exp_ch(k-2)])));
      end else begin
        check("cont_rd_valid_off", 64'(rd_valid), 64'h0);
      end
      check("cont_busy", 64'(busy), (k >= 1 && k <= 9) ? 64'h1 : 64'h0);
      tick();
    end

    // Single read from channel 2.
    a_val[2] = 10'h155;
    addr[20 +: 10] = 10'h155;
    req = 4'b0100;
    #1;
    check("single_grant", 64'(grant), 64'b0100);
    tick();
    req = 4'b0000;
    #1;
    check("single_rom_en", 64'(rom_en), 64'h1);
    check("single_rom_addr", 64'(rom_addr), 64'h155);
    check("single_rd_valid_early", 64'(rd_valid), 64'h0);
    check("single_busy", 64'(busy), 64'h1);
    tick();
    check("single_rd_valid", 64'(rd_valid), 64'b0100);
    check("single_rd_data", 64'(rd_data), 64'(rom_word(10'h155)));
    check("single_rom_en_off", 64'(rom_en), 64'h0);
    check("single_rom_addr_hold", 64'(rom_addr), 64'h155);
    tick();
    check("single_done_valid", 64'(rd_valid), 64'h0);
    check("single_done_busy", 64'(busy), 64'h0);

    // Wrap and skip: pointer sits at 3 after serving channel 2.
    req = 4'b0011;
    #1;
    check("wrap_grant0", 64'(grant), 64'b0001);
    tick();
    check("wrap_rom_addr0", 64'(rom_addr), 64'(a_val[0]));
`ifdef ROMSEL_FIXED_PRIO_EN
    check("wrap_grant1", 64'(grant), 64'b0001);
`else
    check("wrap_grant1", 64'(grant), 64'b0010);
`endif
    tick();
    req = 4'b0000;
    #1;
`ifdef ROMSEL_FIXED_PRIO_EN
    check("wrap_rom_addr1", 64'(rom_addr), 64'(a_val[0]));
`else
    check("wrap_rom_addr1", 64'(rom_addr), 64'(a_val[1]));
`endif
    tick();
    tick();
    check("wrap_drained", 64'(busy), 64'h0);

    // Reset mid-flight: the in-flight read must never surface.
    req = 4'b0100;
    #1;
    check("midrst_grant", 64'(grant), 64'b0100);
    tick();
    req = 4'b0000;
    reset_n = 1'b0;
    #1;
    check("midrst_rom_en", 64'(rom_en), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    tick();
    check("midrst_rd_valid_a", 64'(rd_valid), 64'h0);
    tick();
    check("midrst_rd_valid_b", 64'(rd_valid), 64'h0);
    reset_n = 1'b1;
    req = 4'b1001;
    #1;
    check("midrst_ptr_zero", 64'(grant), 64'b0001);
    tick();
    req = 4'b1000;
    #1;
    check("midrst_grant3", 64'(grant), 64'b1000);
    check("midrst_no_stale", 64'(rd_valid), 64'h0);
    tick();
    req = 4'b0000;
    #1;
    check("midrst_rd_valid0", 64'(rd_valid), 64'b0001);
    check("midrst_rd_data0", 64'(rd_data), 64'(rom_word(a_val[0])));
    tick();
    check("midrst_rd_valid3", 64'(rd_valid), 64'b1000);
    check("midrst_rd_data3", 64'(rd_data), 64'(rom_word(a_val[3])));
    tick();

    // ROM_LAT=3 instance: back-to-back reads from channels 1 then 2.
    addr3[10 +: 10] = 10'h2A1;
    addr3[20 +: 10] = 10'h2B2;
    req3 = 4'b0010;
    #1;
    check("lat3_grant1", 64'(grant3), 64'b0010);
    tick();
    req3 = 4'b0100;
    #1;
    check("lat3_grant2", 64'(grant3), 64'b0100);
    check("lat3_busy_k1", 64'(busy3), 64'h1);
    tick();
    req3 = 4'b0000;
    for (int k = 2; k <= 6; k++) begin
      #1;
      check("lat3_busy", 64'(busy3), (k <= 5) ? 64'h1 : 64'h0);
      if (k == 4) begin
        check("lat3_rd_valid1", 64'(rd_valid3), 64'b0010);
        check("lat3_rd_data1", 64'(rd_data3), 64'(rom_word(10'h2A1)));
      end else if (k == 5) begin
        check("lat3_rd_valid2", 64'(rd_valid3), 64'b0100);
        check("lat3_rd_data2", 64'(rd_data3), 64'(rom_word(10'h2B2)));
      end else begin
        check("lat3_rd_valid_off", 64'(rd_valid3), 64'h0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
